// File: rtl/temp_bram_drain_if.sv
// Output row stream of the temp buffer drain sequencer.
// Master drives rows; slave returns ready.
interface temp_bram_drain_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [ADDR_WIDTH-1:0] idx;

    modport master (
        output data,
        output valid,
        output last,
        output idx,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        input  idx,
        output ready
    );
endinterface

// File: rtl/temp_bram_drain.sv
// Temp buffer read sequencer: issues reads 0..MAC_NUM-1 and
// streams the rows through a 2-entry FIFO with credit-based issue.
module temp_bram_drain #(
    parameter int MAC_NUM    = 8,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = $clog2(MAC_NUM)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_temp_en_o,
    output logic [ADDR_WIDTH-1:0] rd_temp_addr_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    temp_bram_drain_if.master     m
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
        ADDR_WIDTH'(MAC_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] pend_idx_q;
    logic                  pend_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [ADDR_WIDTH-1:0] fifo_idx  [2];
    logic                  fifo_last [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            cnt_q;

    logic       issue;
    logic       push;
    logic       pop;
    logic       head_last;
    logic [1:0] occ;

    assign push      = pend_q;
    assign pop       = m.valid && m.ready;
    assign head_last = fifo_last[rd_ptr_q];
    // Rows held plus the one read still returning from the buffer.
    assign occ       = cnt_q + {1'b0, pend_q};

    assign m.valid = (cnt_q != 2'd0);
    assign m.data  = fifo_data[rd_ptr_q];
    assign m.idx   = fifo_idx[rd_ptr_q];
    assign m.last  = head_last;

    assign rd_temp_addr_o = addr_q;
    assign done_o         = done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_READ;
            end
            S_READ: begin
                if (issue && addr_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue  = 1'b0;
        busy_o = (state_q != S_IDLE);
        if (state_q == S_READ) begin
            issue = ((occ - {1'b0, pop}) < 2'd2);
        end
        rd_temp_en_o = issue;
    end

    // The counter parks on the final address so the bus holds it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start_i) begin
                addr_q <= '0;
            end else if (issue && addr_q != LAST_IDX) begin
                addr_q <= addr_q + 1'b1;
            end
            pend_q <= issue;
            if (issue) pend_idx_q <= addr_q;
            done_q <= (state_q == S_DRAIN) && pop && head_last;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr_q] <= data_i;
                fifo_idx[wr_ptr_q]  <= pend_idx_q;
                fifo_last[wr_ptr_q] <= (pend_idx_q == LAST_IDX);
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
